// File: rtl/link_pkg.sv
// link_pkg: constants and state types shared by the command-link responder.
package link_pkg;
   localparam logic [7:0] POS_ACK      = 8'hA5;
   localparam logic [7:0] ACK          = 8'h5A;
   localparam int         BAUD_DIV_DEF = 2604;
   typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
   typedef enum logic {IDLE, SHIFT} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with input synchronizer, mid-bit sampling and framing check.
module uart_byte_rx
   import link_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       start_edge
);
   localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
   localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
   logic rx_s1, rx_s2, rx_d;
   rx_state_t st;
   logic [11:0] cnt;
   logic [3:0] bits;
   assign start_edge = (st == RX_IDLE) && rx_d && !rx_s2;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_d      <= 1'b1;
         st        <= RX_IDLE;
         cnt       <= '0;
         bits      <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1     <= RX;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (st == RX_IDLE) begin
            if (start_edge) begin
               st  <= RX_START;
               cnt <= HALF;
            end
         end else if (cnt != '0)
            cnt <= cnt - 1'b1;
         else begin
            cnt <= FULL;
            case (st)
               RX_START: begin
                  st   <= rx_s2 ? RX_IDLE : RX_DATA;
                  bits <= '0;
               end
               RX_DATA: begin
                  data <= {rx_s2, data[7:1]};
                  bits <= bits + 1'b1;
                  if (bits == 4'd7) st <= RX_STOP;
               end
               default: begin
                  valid     <= rx_s2;
                  frame_err <= !rx_s2;
                  st        <= RX_IDLE;
               end
            endcase
         end
      end
endmodule

// File: rtl/cmd_link_responder.sv
// cmd_link_responder: assembles UART byte pairs into 16-bit commands and
// serializes one-byte responses back onto the link.
module cmd_link_responder
   import link_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF,
   parameter int TIMEOUT  = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy
);
   localparam logic [11:0] FULL   = 12'(BAUD_DIV - 1);
   localparam logic [16:0] TO_MAX = 17'(TIMEOUT);
   logic [7:0] rx_byte, hi;
   logic rx_valid, rx_err, rx_edge;
   asm_state_t asm_st;
   logic [16:0] to_cnt;
   tx_state_t tx_st;
   logic [9:0] tx_sh;
   logic [11:0] tx_cnt;
   logic [3:0] tx_bits;

   uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .RX        (RX),
      .data      (rx_byte),
      .valid     (rx_valid),
      .frame_err (rx_err),
      .start_edge(rx_edge)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         asm_st  <= WAIT_HIGH;
         hi      <= '0;
         to_cnt  <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
      end else begin
         if (rx_valid && asm_st == WAIT_LOW)
            cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || (rx_edge && asm_st == WAIT_HIGH))
            cmd_rdy <= 1'b0;
         if (rx_err)
            asm_st <= WAIT_HIGH;
         else if (rx_valid) begin
            if (asm_st == WAIT_HIGH) begin
               hi     <= rx_byte;
               to_cnt <= '0;
               asm_st <= WAIT_LOW;
            end else begin
               cmd    <= {hi, rx_byte};
               asm_st <= WAIT_HIGH;
            end
         end else if (asm_st == WAIT_LOW) begin
            // a stalled low byte abandons the pending high byte
            if (rx_edge) to_cnt <= '0;
            else if (to_cnt == TO_MAX) asm_st <= WAIT_HIGH;
            else to_cnt <= to_cnt + 1'b1;
         end
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_st     <= IDLE;
         tx_sh     <= '1;
         tx_cnt    <= '0;
         tx_bits   <= '0;
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= 1'b0;
         if (tx_st == IDLE) begin
            if (send_resp) begin
               tx_sh   <= {1'b1, resp, 1'b0};
               TX      <= 1'b0;
               tx_busy <= 1'b1;
               tx_cnt  <= FULL;
               tx_bits <= '0;
               tx_st   <= SHIFT;
            end
         end else if (tx_cnt != '0)
            tx_cnt <= tx_cnt - 1'b1;
         else if (tx_bits == 4'd9) begin
            tx_st     <= IDLE;
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b1;
         end else begin
            tx_sh   <= {1'b1, tx_sh[9:1]};
            TX      <= tx_sh[1];
            tx_bits <= tx_bits + 1'b1;
            tx_cnt  <= FULL;
         end
      end
endmodule

// File: tb/tb_cmd_link_responder.sv
// tb_cmd_link_responder: directed scoreboard bench for the command-link responder.
module tb_cmd_link_responder;
   import link_pkg::*;
   localparam int B  = 16;
   localparam int TO = 600;
   logic clk = 1'b0, rst_n = 1'b0, RX = 1'b1, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
   logic TX, cmd_rdy, resp_sent, tx_busy;
   logic [15:0] cmd;
   logic [7:0] resp = '0;
   int vectors = 0, errs = 0;
   logic [15:0] cmdq[$];
   logic [7:0] txq[$];

   always #5 clk = ~clk;

   cmd_link_responder #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .cmd        (cmd),
      .cmd_rdy    (cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy),
      .resp       (resp),
      .send_resp  (send_resp),
      .resp_sent  (resp_sent),
      .tx_busy    (tx_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = f[i];
         repeat (B) @(negedge clk);
      end
      RX = 1'b1;
   endtask

   task automatic wait_cmd(input string tag);
      int n;
      n = 0;
      while (!cmd_rdy && n < 60000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, 32'(cmd_rdy), 1);
      chk({tag, "_cmd"}, 32'(cmd), cmdq.size() != 0 ? 32'(cmdq.pop_front()) : 32'hDEAD_BEEF);
   endtask

   task automatic clr_pulse(input string tag);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk(tag, 32'(cmd_rdy), 0);
   endtask

   task automatic tx_decode(output logic [7:0] b, output logic ok);
      int n;
      n = 0;
      b = '0;
      while (TX !== 1'b0 && n < 20 * B) begin
         @(negedge clk);
         n++;
      end
      ok = (TX === 1'b0);
      repeat (B / 2) @(negedge clk);
      if (TX !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (B) @(negedge clk);
         b[i] = TX;
      end
      repeat (B) @(negedge clk);
      if (TX !== 1'b1) ok = 1'b0;
   endtask

   task automatic tx_check(input logic [7:0] r, input logic [9:0] seq);
      logic [9:0] obs;
      logic held, busy_ok;
      int pulses;
      obs = '0;
      held = 1'b1;
      busy_ok = 1'b1;
      pulses = 0;
      @(negedge clk);
      resp = r;
      send_resp = 1'b1;
      txq.push_back(r);
      @(negedge clk);
      send_resp = 1'b0;
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < B; j++) begin
            if (j == 0) obs[i] = TX;
            else if (TX !== obs[i]) held = 1'b0;
            if (resp_sent) pulses++;
            if (!tx_busy) busy_ok = 1'b0;
            @(negedge clk);
         end
      chk($sformatf("tx%02h_seq", r), 32'(obs), 32'(seq));
      chk($sformatf("tx%02h_held", r), 32'(held), 1);
      chk($sformatf("tx%02h_early_sent", r), pulses, 0);
      chk($sformatf("tx%02h_busy", r), 32'(busy_ok), 1);
      chk($sformatf("tx%02h_decode", r), 32'(obs[8:1]), 32'(txq.pop_front()));
      chk($sformatf("tx%02h_sent", r), 32'(resp_sent), 1);
      chk($sformatf("tx%02h_idle_busy", r), 32'(tx_busy), 0);
      chk($sformatf("tx%02h_idle_tx", r), 32'(TX), 1);
      @(negedge clk);
      chk($sformatf("tx%02h_sent_pulse", r), 32'(resp_sent), 0);
   endtask

   initial begin
      logic ok;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tx", 32'(TX), 1);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_rdy", 32'(cmd_rdy), 0);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_sent", 32'(resp_sent), 0);
      ok = 1'b1;
      repeat (500) begin
         @(negedge clk);
         if (TX !== 1'b1 || cmd !== 16'h0 || cmd_rdy !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
      end
      chk("idle_hold", 32'(ok), 1);

      cmdq.push_back(16'h2000);
      send_byte(8'h20, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_cmd("c2000");
      clr_pulse("clr_rdy");
      chk("cmd_hold", 32'(cmd), 32'h2000);

      tx_check(POS_ACK, 10'b1101001010);
      tx_check(ACK, 10'b1010110100);

      send_byte(8'h77, 1'b0);
      repeat (2 * B) @(negedge clk);
      chk("ferr_no_rdy", 32'(cmd_rdy), 0);
      cmdq.push_back(16'h4123);
      send_byte(8'h41, 1'b1);
      send_byte(8'h23, 1'b1);
      wait_cmd("c4123");

      fork
         send_byte(8'hFF, 1'b1);
         begin
            repeat (B) @(negedge clk);
            chk("edge_clr", 32'(cmd_rdy), 0);
         end
      join
      repeat (TO + 100) @(negedge clk);
      chk("to_no_rdy", 32'(cmd_rdy), 0);
      cmdq.push_back(16'h5A01);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_cmd("c5a01");
      clr_pulse("clr_rdy2");

      fork
         begin
            logic [7:0] b;
            logic dok;
            int pulses;
            pulses = 0;
            resp = 8'hC3;
            send_resp = 1'b1;
            txq.push_back(8'hC3);
            @(negedge clk);
            send_resp = 1'b0;
            fork
               tx_decode(b, dok);
               begin
                  repeat (3 * B) @(negedge clk);
                  resp = 8'h99;
                  send_resp = 1'b1;
                  @(negedge clk);
                  send_resp = 1'b0;
               end
               repeat (22 * B) begin
                  @(negedge clk);
                  if (resp_sent) pulses++;
               end
            join
            chk("busy_frame_ok", 32'(dok), 1);
            chk("busy_decode", 32'(b), 32'(txq.pop_front()));
            chk("busy_one_sent", pulses, 1);
         end
         begin
            cmdq.push_back(16'h1234);
            send_byte(8'h12, 1'b1);
            send_byte(8'h34, 1'b1);
            wait_cmd("c1234_during_tx");
         end
      join

      @(negedge clk);
      resp = POS_ACK;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (3 * B) @(negedge clk);
      chk("midtx_busy", 32'(tx_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx", 32'(TX), 1);
      chk("arst_busy", 32'(tx_busy), 0);
      chk("arst_cmd", 32'(cmd), 0);
      chk("arst_rdy", 32'(cmd_rdy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_tx", 32'(TX), 1);
      chk("post_rst_sent", 32'(resp_sent), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/cmd_link_responder.md
# cmd_link_responder

Robot-side end of the serial command link: deserializes 8N1 UART bytes from the host/Bluetooth line and assembles them high-byte-first into 16-bit commands for the command processor. It also serializes one-byte responses (0xA5 positive ack, 0x5A ack) back onto the line. It sits between the RX/TX pins and `cmd_proc`.

## Interface
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud)
- TIMEOUT, 65536, max clocks from high-byte stop sample to low-byte start edge

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- RX  in  1  serial in, asynchronous, idles high
- TX  out  1  serial out, idles high
- cmd  out  16  last assembled command, `{high, low}`
- cmd_rdy  out  1  level; a new `cmd` is valid
- clr_cmd_rdy  in  1  pulse; consumer has taken `cmd`
- resp  in  8  response byte, sampled when `send_resp` is high
- send_resp  in  1  pulse; transmit `resp`
- resp_sent  out  1  one-cycle pulse at end of response frame
- tx_busy  out  1  high while a response frame is on TX

## Operation
- **RX front end:** RX is double-flopped; both flops preset to 1 on reset.
  - IDLE: a synchronized falling edge starts a frame.
  - Sampling is at BAUD_DIV/2 (start-bit check), then every BAUD_DIV.
  - If the start sample is high, the frame is a glitch: return to IDLE.
  - 8 data bits are shifted in LSB first, then the stop bit is sampled.
  - Stop bit = 1: byte valid (1-cycle internal strobe). Stop bit = 0: framing error, byte discarded, assembler forced to WAIT_HIGH.
- **Assembler FSM, states WAIT_HIGH / WAIT_LOW:**
  - WAIT_HIGH + byte valid: latch high byte, go to WAIT_LOW, start the timeout counter.
  - WAIT_LOW + byte valid: `cmd <= {high, byte}`, set `cmd_rdy`, go to WAIT_HIGH.
  - WAIT_LOW: the counter clears when a start edge arrives. If it reaches TIMEOUT first, drop the high byte and go to WAIT_HIGH.
- **cmd_rdy:**
  - Cleared by `clr_cmd_rdy`.
  - Also cleared by the start edge of a new frame while in WAIT_HIGH.
  - Set has priority over clear in the same cycle.
  - `cmd` holds its value until the next completed pair.
- **TX:** states IDLE / SHIFT.
  - `send_resp` in IDLE loads `{1, resp, 0}` into a 10-bit shifter, raises `tx_busy`, and drives TX low on the next cycle.
  - Each bit is held exactly BAUD_DIV clocks, LSB first after the start bit.
  - After 10 bits: `resp_sent` pulses, `tx_busy` falls, TX = 1.
  - `send_resp` while busy is ignored; it is neither queued nor corrupting.
- RX and TX are fully independent and may run at the same time.

## Timing
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0; FSMs in WAIT_HIGH / IDLE.
- Reset mid-frame: all outputs return to reset values immediately (async); the partial byte is lost.
- RX latency: `cmd_rdy` rises 3 clocks after the low byte's stop-bit sample (2 sync flops + 1 register). That sample is 9.5·BAUD_DIV after the start edge.
- A full command takes ≤ 20·BAUD_DIV + TIMEOUT slack. Back-to-back bytes: 52080 clocks at default BAUD_DIV.
- TX: TX falls 1 clock after `send_resp`. The frame lasts exactly 10·BAUD_DIV clocks. `resp_sent` is high on the cycle after the last stop-bit clock. The next `send_resp` is accepted that same cycle.
- Baud counters are 12 bits, bit counters 4 bits, timeout counter 17 bits; all are saturating or reloaded, never free-wrapping.

## Structure
- Shared package `link_pkg`:
  - constants POS_ACK=8'hA5, ACK=8'h5A, default BAUD_DIV
  - typedefs `asm_state_t` {WAIT_HIGH, WAIT_LOW} and `tx_state_t` {IDLE, SHIFT}
- One sub-module: `uart_byte_rx` (sync + start detect + sampling + framing check; outputs byte, valid, frame_err, start_edge).
- TX and the assembler stay in the top module.

## Test plan
- Reset: TX=1, cmd=0x0000, cmd_rdy=0, tx_busy=0 at the first negedge after rst_n rises; these hold for 500 clocks with RX idle.
- Bench transmits 0x20 then 0x00 back-to-back: `cmd`=0x2000 and `cmd_rdy`=1 within 60000 clocks. A `clr_cmd_rdy` pulse drops `cmd_rdy` next cycle.
- `send_resp` with `resp`=0xA5: TX bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clocks. `resp_sent` comes at clock 10·BAUD_DIV+1, and the bench receiver decodes 0xA5. Repeat with 0x5A.
- High byte sent with stop=0, then a valid pair 0x41, 0x23: no `cmd_rdy` for the bad byte. Then `cmd`=0x4123.
- High byte 0xFF, then silence > TIMEOUT, then 0x5A, 0x01: `cmd`=0x5A01 (stale 0xFF discarded).
- Busy/reset corners: a second `send_resp` mid-frame is ignored (exactly one `resp_sent`). `rst_n` low mid-TX gives TX=1 and tx_busy=0 immediately. A command arriving during TX still assembles correctly.
